rc4_scramble: RTL and testbench
===============================

// Module: rc4_scramble
// PURPOSE
// - RC4 key-scheduling (KSA) engine: permutes a 256-byte S-array already held in an
//   external single-port RAM (S[i]=i loaded by an earlier init stage) using a 24-bit key.
// - Sits between the S-init stage and the PRGA/decrypt stage of the RC4 decryptor.
// - Owns the S-RAM port while busy; pulses nothing, holds done until the next start.
// PARAMETERS
// - KEY_BYTES  3    key length in bytes (secret_key width = 8*KEY_BYTES)
// - MEM_DEPTH  256  S-array entries; index/j arithmetic is mod 256 (8-bit wrap)
// PORTS
// - clk              in   1   single system clock, rising edge
// - reset            in   1   asynchronous, active-low reset
// - start_scramble   in   1   request; sampled high in IDLE starts one KSA pass
// - secret_key       in   24  key; byte0=[23:16], byte1=[15:8], byte2=[7:0]
// - ram_q            in   8   S-RAM read data, valid 1 cycle after address presented
// - ram_address      out  8   S-RAM address
// - ram_data         out  8   S-RAM write data
// - ram_wren         out  1   S-RAM write enable (write on rising clk edge)
// - done_scrambling  out  1   high while in DONE
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, i=0, j=0, key index k=0, ram_address=0,
//   ram_data=0, ram_wren=0, done_scrambling=0.
// - Algorithm: j=0; for i=0..255: j=(j+S[i]+key[i mod 3]) mod 256; swap S[i],S[j].
// - i mod 3 tracked by a 2-bit counter k (0,1,2 wrap), no divider.
// - secret_key sampled once on leaving IDLE; changes mid-pass are ignored.
// - FSM (one state per clock; outputs registered, fixed per state):
//   IDLE    : wren=0; start_scramble=1 -> READ_I (clear i,j,k,done)
//   READ_I  : address=i -> WAIT_I
//   WAIT_I  : hold address -> CALC_J
//   CALC_J  : si<=ram_q; j<=j+ram_q+key[k] -> READ_J
//   READ_J  : address=j -> WAIT_J
//   WAIT_J  : hold address -> WRITE_I
//   WRITE_I : sj<=ram_q; address=i, data=sj, wren=1 -> WRITE_J
//   WRITE_J : address=j, data=si, wren=1 -> INC
//   INC     : wren=0; i==255 -> DONE, else i++, k=(k+1)%3 -> READ_I
//   DONE    : done_scrambling=1; start_scramble=1 -> new pass (READ_I)
// - Exactly 8 cycles per iteration; done_scrambling rises 2048 clocks after the
//   edge that sampled start_scramble=1.
// - i==j: both writes target same address with same value; result correct.
// - i wraps at 255 only via DONE; j wraps mod 256 silently.
// - start_scramble while busy: ignored. Reset mid-pass: abort to IDLE immediately,
//   RAM left partially permuted.
// - ram_wren high only in WRITE_I/WRITE_J; never two writes per state.
// STRUCTURE
// - Package rc4_pkg: ksa_state_t enum, MEM_DEPTH, KEY_BYTES, key-byte select function.
// - Single module, no sub-modules; RAM instantiated outside by parent.
// TESTING (bench: behavioural 256x8 RAM, 1-cycle read latency, S[i]=i preload)
// - Reset held low -> all outputs 0, state IDLE; no writes with start_scramble=0.
// - key=24'h000000 -> iterations 0,1 write S unchanged; iteration 2 writes addr2<-3,
//   addr3<-2.
// - key=24'h123456 -> first writes: addr 0x00<-0x12, addr 0x12<-0x00.
// - Full pass, key=24'h000249 -> final RAM equals software KSA model byte-for-byte;
//   done_scrambling rises 2048 cycles after start, stays high.
// - start_scramble pulsed mid-pass -> no restart, cycle count unchanged.
// - reset asserted mid-pass -> outputs 0 asynchronously; new start gives correct result
//   only after RAM re-preload.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine.
//   ksa_state_t : KSA controller states (one state per clock)
//   KEY_BYTES   : default key length in bytes
//   MEM_DEPTH   : default S-array depth (power of two, index wraps naturally)
//   key_byte()  : picks byte k of a key, byte 0 being the most significant
package rc4_pkg;

  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned MEM_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    CALC_J,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    INC,
    DONE
  } ksa_state_t;

  // key is right-aligned in 32 bits; nbytes (1..4) gives the real key length.
  function automatic logic [7:0] key_byte(input logic [31:0] key,
                                          input logic [1:0] k,
                                          input int unsigned nbytes);
    logic [7:0] sel;
    sel = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b < nbytes && 32'(k) == b) begin
        sel = key[8*(nbytes-1-b) +: 8];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rc4_scramble.sv
// RC4 key-scheduling (KSA) engine. Permutes an S-array held in an external
// single-port RAM (preloaded with S[i]=i) using secret_key:
//   j = 0; for i in 0..MEM_DEPTH-1: j += S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
// Every iteration takes exactly 8 clocks; done_scrambling holds until next start.
// Ports:
//   clk             : system clock, rising edge
//   reset           : asynchronous, active-low reset
//   start_scramble  : starts a pass when sampled high in IDLE or DONE
//   secret_key      : key, byte0 in the most significant bits; latched at start
//   ram_q           : S-RAM read data, valid one cycle after the address
//   ram_address     : S-RAM address (registered)
//   ram_data        : S-RAM write data (registered)
//   ram_wren        : S-RAM write enable (registered)
//   done_scrambling : high while the pass is complete
module rc4_scramble
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = rc4_pkg::KEY_BYTES,
  parameter int unsigned MEM_DEPTH = rc4_pkg::MEM_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_scramble,
  input  logic [8*KEY_BYTES-1:0]       secret_key,
  input  logic [7:0]                   ram_q,
  output logic [$clog2(MEM_DEPTH)-1:0] ram_address,
  output logic [7:0]                   ram_data,
  output logic                         ram_wren,
  output logic                         done_scrambling
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  ksa_state_t      state, state_n;
  logic [AW-1:0]   i, i_n;
  logic [AW-1:0]   j, j_n;
  logic [1:0]      k, k_n;
  logic [7:0]      si, si_n;
  logic [7:0]      sj, sj_n;
  logic [31:0]     key_r, key_n;
  logic [AW-1:0]   addr_n;
  logic [7:0]      data_n;
  logic            wren_n;
  logic            done_n;
  logic [7:0]      kb;

  assign kb = key_byte(key_r, k, KEY_BYTES);

  // Next-state and datapath updates, then outputs derived from the state being
  // entered so that the registered outputs are constant for each state.
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    si_n    = si;
    sj_n    = sj;
    key_n   = key_r;
    addr_n  = ram_address;
    data_n  = ram_data;
    wren_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start_scramble) begin
          state_n = READ_I;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
          key_n   = 32'(secret_key);
        end
      end
      READ_I:  state_n = WAIT_I;
      WAIT_I:  state_n = CALC_J;
      CALC_J: begin
        si_n    = ram_q;
        j_n     = j + AW'(ram_q) + AW'(kb);
        state_n = READ_J;
      end
      READ_J:  state_n = WAIT_J;
      // S[j] is already on ram_q here; capturing it one edge early lets
      // WRITE_I present it as registered write data.
      WAIT_J: begin
        sj_n    = ram_q;
        state_n = WRITE_I;
      end
      WRITE_I: state_n = WRITE_J;
      WRITE_J: state_n = INC;
      INC: begin
        if (32'(i) == MEM_DEPTH - 1) begin
          state_n = DONE;
        end else begin
          i_n     = i + 1'b1;
          k_n     = (32'(k) == KEY_BYTES - 1) ? '0 : k + 2'd1;
          state_n = READ_I;
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      READ_I, WAIT_I, CALC_J: addr_n = i_n;
      READ_J, WAIT_J:         addr_n = j_n;
      WRITE_I: begin
        addr_n = i_n;
        data_n = sj_n;
        wren_n = 1'b1;
      end
      WRITE_J: begin
        addr_n = j_n;
        data_n = si_n;
        wren_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      i               <= '0;
      j               <= '0;
      k               <= '0;
      si              <= '0;
      sj              <= '0;
      key_r           <= '0;
      ram_address     <= '0;
      ram_data        <= '0;
      ram_wren        <= 1'b0;
      done_scrambling <= 1'b0;
    end else begin
      state           <= state_n;
      i               <= i_n;
      j               <= j_n;
      k               <= k_n;
      si              <= si_n;
      sj              <= sj_n;
      key_r           <= key_n;
      ram_address     <= addr_n;
      ram_data        <= data_n;
      ram_wren        <= wren_n;
      done_scrambling <= done_n;
    end
  end

endmodule

// File: tb/tb_rc4_scramble.sv
// Self-checking bench for rc4_scramble with a behavioural 256x8 RAM
// (one-cycle read latency). Expected RAM writes are queued from a software
// KSA model when a pass is started and compared as the DUT issues them.
module tb_rc4_scramble;

  logic        clk;
  logic        reset;
  logic        start_scramble;
  logic [23:0] secret_key;
  logic [7:0]  ram_q;
  logic [7:0]  ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        done_scrambling;

  logic [7:0]  mem     [256];
  logic [7:0]  exp_mem [256];
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];

  int tests;
  int fails;

  rc4_scramble #(.KEY_BYTES(3), .MEM_DEPTH(256)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_scramble  (start_scramble),
    .secret_key      (secret_key),
    .ram_q           (ram_q),
    .ram_address     (ram_address),
    .ram_data        (ram_data),
    .ram_wren        (ram_wren),
    .done_scrambling (done_scrambling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // Scoreboard: each write seen mid-cycle is matched against the model queue.
  always @(negedge clk) begin
    if (reset && ram_wren) begin
      logic [15:0] e;
      wr_log.push_back({ram_address, ram_data});
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write: got addr=%02h data=%02h, required no write",
                 ram_address, ram_data);
      end else begin
        e = exp_q.pop_front();
        if ({ram_address, ram_data} !== e) begin
          fails++;
          $display("FAIL sb_write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   ram_address, ram_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic preload();
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
  endtask

  task automatic build_expect(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] jj, t, kbyte;
    exp_q.delete();
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    jj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      kbyte = 8'((key >> (8 * (2 - (a % 3)))) & 24'hff);
      jj = jj + s[a] + kbyte;
      exp_q.push_back({8'(a), s[jj]});
      exp_q.push_back({jj, s[a]});
      t = s[a]; s[a] = s[jj]; s[jj] = t;
    end
    for (int a = 0; a < 256; a++) exp_mem[a] = s[a];
  endtask

  // Starts a pass and counts clocks from the sampling edge to done_scrambling.
  task automatic start_and_wait(input logic [23:0] key, input bit pulse_mid,
                                output int n);
    @(negedge clk);
    secret_key     = key;
    start_scramble = 1'b1;
    @(posedge clk); #1;
    start_scramble = 1'b0;
    secret_key     = ~key;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      start_scramble = pulse_mid && (n == 100 || n == 1500);
      if (done_scrambling) break;
    end
    start_scramble = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== exp_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL %s: %0d bytes differ, first addr=%02h got %02h required %02h",
               name, bad, first[7:0], mem[first], exp_mem[first]);
    end
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_writes_left: got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start_scramble = 1'b0; secret_key = 24'h0;
    preload();
    repeat (3) @(negedge clk);
    tests++; if (ram_address !== 8'h00) begin fails++; $display("FAIL reset_addr: got %02h required 00", ram_address); end
    tests++; if (ram_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %02h required 00", ram_data); end
    tests++; if (ram_wren !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b required 0", ram_wren); end
    tests++; if (done_scrambling !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done_scrambling); end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (wr_log.size() !== 0) begin fails++; $display("FAIL idle_no_write: got %0d writes required 0", wr_log.size()); end
    tests++; if (done_scrambling !== 1'b0) begin fails++; $display("FAIL idle_done: got %b required 0", done_scrambling); end
  endtask

  task automatic test_key_zero();
    logic [15:0] first6 [6];
    int n;
    first6[0] = 16'h0000; first6[1] = 16'h0000; first6[2] = 16'h0101;
    first6[3] = 16'h0101; first6[4] = 16'h0203; first6[5] = 16'h0302;
    preload(); build_expect(24'h000000); wr_log.delete();
    start_and_wait(24'h000000, 1'b0, n);
    tests++; if (n !== 2048) begin fails++; $display("FAIL key0_latency: got %0d required 2048", n); end
    for (int w = 0; w < 6; w++) begin
      tests++;
      if (wr_log.size() <= w || wr_log[w] !== first6[w]) begin
        fails++;
        $display("FAIL key0_write%0d: got %04h required %04h", w,
                 (wr_log.size() > w) ? wr_log[w] : 16'hxxxx, first6[w]);
      end
    end
    check_mem("key0_ram");
  endtask

  task automatic test_key_123456();
    int n;
    preload(); build_expect(24'h123456); wr_log.delete();
    start_and_wait(24'h123456, 1'b0, n);
    tests++; if (n !== 2048) begin fails++; $display("FAIL key123456_latency: got %0d required 2048", n); end
    tests++;
    if (wr_log.size() < 2 || wr_log[0] !== 16'h0012 || wr_log[1] !== 16'h1200) begin
      fails++;
      $display("FAIL key123456_first_writes: got %04h %04h required 0012 1200",
               (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx,
               (wr_log.size() > 1) ? wr_log[1] : 16'hxxxx);
    end
    check_mem("key123456_ram");
  endtask

  task automatic test_back_to_back();
    int n;
    preload(); build_expect(24'h000249);
    start_and_wait(24'h000249, 1'b1, n);
    tests++; if (n !== 2048) begin fails++; $display("FAIL busy_start_latency: got %0d required 2048", n); end
    check_mem("key000249_ram");
    repeat (5) @(negedge clk);
    tests++; if (done_scrambling !== 1'b1) begin fails++; $display("FAIL done_hold: got %b required 1", done_scrambling); end
    tests++; if (ram_wren !== 1'b0) begin fails++; $display("FAIL done_wren: got %b required 0", ram_wren); end
  endtask

  task automatic test_reset_mid();
    int n;
    preload(); build_expect(24'h000249);
    @(negedge clk);
    secret_key = 24'h000249; start_scramble = 1'b1;
    @(posedge clk); #1;
    start_scramble = 1'b0;
    for (n = 0; n < 405; n++) @(posedge clk);
    #1;
    tests++; if (ram_wren !== 1'b1 || ram_address !== 8'd50) begin
      fails++; $display("FAIL mid_write_i: got wren=%b addr=%02h required wren=1 addr=32", ram_wren, ram_address);
    end
    #2 reset = 1'b0;
    #1;
    tests++; if (ram_address !== 8'h00) begin fails++; $display("FAIL midrst_addr: got %02h required 00", ram_address); end
    tests++; if (ram_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %02h required 00", ram_data); end
    tests++; if (ram_wren !== 1'b0) begin fails++; $display("FAIL midrst_wren: got %b required 0", ram_wren); end
    tests++; if (done_scrambling !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b required 0", done_scrambling); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    preload(); build_expect(24'h000249);
    start_and_wait(24'h000249, 1'b0, n);
    tests++; if (n !== 2048) begin fails++; $display("FAIL after_rst_latency: got %0d required 2048", n); end
    check_mem("after_rst_ram");
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_key_zero();
    test_key_123456();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
